// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Single-port data memory that answers load/store requests with a one-cycle
//   latency valid/ready response channel. Stores write the enabled byte lanes
//   at the acceptance edge. Loads read the synchronous array at the acceptance
//   edge, and the array output is presented in the first response cycle.
//   Out-of-range addresses and stores with no enabled lanes are answered with
//   rsp_error=1. They do not touch memory, and their rdata is 0.
//
// Parameters
//   MEM_WORDS   : number of 32-bit words in the data memory
//   ID_WIDTH    : width of the request/response tag
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   flush       : drop any pending response, accept nothing this cycle
//   req_valid   : request presented
//   req_ready   : request accepted this cycle (when req_valid)
//   req_write   : 1 = store, 0 = load
//   req_addr    : byte address; bits [1:0] ignored for word select
//   req_byte_en : store lane enables, bit i -> bits [8i+7:8i]
//   req_wdata   : store data
//   req_id      : tag echoed on the response
//   rsp_valid   : response presented
//   rsp_ready   : consumer takes the response this cycle
//   rsp_rdata   : load data (0 for stores and errors)
//   rsp_id      : tag of the answered request
//   rsp_write   : req_write of the answered request
//   rsp_error   : request was rejected
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int MEM_WORDS = 4096,
    parameter int ID_WIDTH  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [31:0]         req_addr,
    input  logic [3:0]          req_byte_en,
    input  logic [31:0]         req_wdata,
    input  logic [ID_WIDTH-1:0] req_id,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_rdata,
    output logic [ID_WIDTH-1:0] rsp_id,
    output logic                rsp_write,
    output logic                rsp_error
);

    localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    // Response FSM encoding
    localparam logic [1:0] IDLE  = 2'd0;  // no response pending
    localparam logic [1:0] FRESH = 2'd1;  // first response cycle, data from array output
    localparam logic [1:0] HELD  = 2'd2;  // stalled response, data from hold register

    logic [1:0]          state;
    logic [1:0]          state_nxt;

    logic                accept;
    logic                req_err;
    logic [IDX_W-1:0]    req_idx;

    logic [31:0]         mem [0:MEM_WORDS-1];
    logic [31:0]         mem_rdata;

    logic [31:0]         hold_q;
    logic                rsp_load_ok_q;
    logic [ID_WIDTH-1:0] rsp_id_q;
    logic                rsp_write_q;
    logic                rsp_error_q;
    logic [31:0]         rdata_cur;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    // rsp_ready feeds req_ready combinationally. This lets a new request
    // be accepted in the same cycle the current response is taken.
    // Gating with rst keeps req_ready low while reset is held.
    assign req_ready = rst && ((state == IDLE) || rsp_ready) && !flush;
    assign accept    = req_valid && req_ready;
    assign req_idx   = req_addr[IDX_W+1:2];

    // The compare is 33 bits wide, so a MEM_WORDS near 2^30 cannot wrap it.
    assign req_err   = ({1'b0, req_addr} >= MEM_BYTES) ||
                       (req_write && (req_byte_en == 4'b0000));

    // ------------------------------------------------------------------
    // Memory array: not reset, synchronous read, byte-lane write
    // ------------------------------------------------------------------
    // At most one request is accepted per cycle, so a load never shares an
    // edge with a store. A load one cycle after a store therefore reads
    // the updated word.
    always_ff @(posedge clk) begin
        if (accept && !req_err) begin
            if (req_write) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (req_byte_en[i]) begin
                        mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end else begin
                mem_rdata <= mem[req_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = FRESH;
        end else begin
            case (state)
                FRESH:   state_nxt = rsp_ready ? IDLE : HELD;
                HELD:    state_nxt = rsp_ready ? IDLE : HELD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response metadata changes only on acceptance. Acceptance needs
    // rsp_ready whenever a response is pending, so the fields cannot
    // change during a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_id_q      <= '0;
            rsp_write_q   <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_load_ok_q <= 1'b0;
        end else if (accept) begin
            rsp_id_q      <= req_id;
            rsp_write_q   <= req_write;
            rsp_error_q   <= req_err;
            rsp_load_ok_q <= !req_write && !req_err;
        end
    end

    // The array output register is overwritten by the next load, so a
    // stalled FRESH response is copied into hold_q before it can be lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else if ((state == FRESH) && !rsp_ready && !flush) begin
            hold_q <= rdata_cur;
        end
    end

    always_comb begin
        rdata_cur = '0;
        case (state)
            FRESH:   rdata_cur = rsp_load_ok_q ? mem_rdata : '0;
            HELD:    rdata_cur = hold_q;
            default: rdata_cur = '0;
        endcase
    end

    assign rsp_valid = (state == FRESH) || (state == HELD);
    assign rsp_rdata = rdata_cur;
    assign rsp_id    = rsp_id_q;
    assign rsp_write = rsp_write_q;
    assign rsp_error = rsp_error_q;

endmodule
